// File: rtl/xs_sdr_pkg.sv
// rtl/xs_sdr_pkg.sv - shared types and widths for the XSleena SDRAM read arbiter
package xs_sdr_pkg;

  localparam int XS_SDR_AW = 25;
  localparam int XS_SDR_DW = 16;

  typedef enum logic [2:0] {
    OBJ  = 3'd0,
    BG1  = 3'd1,
    BG2  = 3'd2,
    MCPU = 3'd3,
    SCPU = 3'd4
  } xs_sdr_client_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } xs_sdr_state_t;

endpackage

// File: rtl/xs_sdr_prio_pick.sv
// rtl/xs_sdr_prio_pick.sv - combinational winner select: starved CPUs, then video, then CPU round-robin
module xs_sdr_prio_pick
  import xs_sdr_pkg::*;
(
  input  logic [4:0]     req_i,
  input  logic [1:0]     starved_i,
  input  logic           rr_i,
  output xs_sdr_client_t winner_o,
  output logic           valid_o
);

  logic           st_m;
  logic           st_s;
  xs_sdr_client_t rr_cpu;

  // A stale starved flag for a CPU that has just dropped req must not win.
  assign st_m   = starved_i[0] & req_i[3];
  assign st_s   = starved_i[1] & req_i[4];
  assign rr_cpu = rr_i ? SCPU : MCPU;

  always_comb begin
    winner_o = OBJ;
    valid_o  = |req_i;
    if (st_m && st_s)            winner_o = rr_cpu;
    else if (st_m)               winner_o = MCPU;
    else if (st_s)               winner_o = SCPU;
    else if (req_i[0])           winner_o = OBJ;
    else if (req_i[1])           winner_o = BG1;
    else if (req_i[2])           winner_o = BG2;
    else if (req_i[3] && req_i[4]) winner_o = rr_cpu;
    else if (req_i[3])           winner_o = MCPU;
    else if (req_i[4])           winner_o = SCPU;
  end

endmodule

// File: rtl/xsleena_sdr_arbiter.sv
// rtl/xsleena_sdr_arbiter.sv - five-client single-outstanding SDRAM read arbiter
module xsleena_sdr_arbiter
  import xs_sdr_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [XS_SDR_AW-1:0] mcpu_addr,
  input  logic [XS_SDR_AW-1:0] scpu_addr,
  input  logic [XS_SDR_AW-1:0] obj_addr,
  input  logic [XS_SDR_AW-1:0] bg1_addr,
  input  logic [XS_SDR_AW-1:0] bg2_addr,
  input  logic                 mcpu_req,
  input  logic                 scpu_req,
  input  logic                 obj_req,
  input  logic                 bg1_req,
  input  logic                 bg2_req,
  output logic                 mcpu_rdy,
  output logic                 scpu_rdy,
  output logic                 obj_rdy,
  output logic                 bg1_rdy,
  output logic                 bg2_rdy,
  output logic [XS_SDR_DW-1:0] mcpu_dout,
  output logic [XS_SDR_DW-1:0] scpu_dout,
  output logic [XS_SDR_DW-1:0] obj_dout,
  output logic [XS_SDR_DW-1:0] bg1_dout,
  output logic [XS_SDR_DW-1:0] bg2_dout,
  output logic [XS_SDR_AW-1:0] sdr_addr,
  output logic                 sdr_req,
  input  logic                 sdr_ack,
  input  logic                 sdr_valid,
  input  logic [XS_SDR_DW-1:0] sdr_data
);

  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

  xs_sdr_state_t        state_q, state_d;
  xs_sdr_client_t       client_q, client_d;
  xs_sdr_client_t       pick;
  logic                 pick_valid;
  logic                 grant;
  logic [4:0]           req;
  logic [4:0]           rdy_q, rdy_d;
  logic [XS_SDR_DW-1:0] dout_q [5];
  logic [XS_SDR_DW-1:0] dout_d [5];
  logic [XS_SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
  logic [XS_SDR_AW-1:0] pick_addr;
  logic                 sdr_req_q, sdr_req_d;
  logic                 rr_q, rr_d;
  logic [7:0]           mwait_q, mwait_d;
  logic [7:0]           swait_q, swait_d;
  logic                 busy_m, busy_s;

  assign req = {scpu_req, mcpu_req, bg2_req, bg1_req, obj_req};

  xs_sdr_prio_pick u_pick (
    .req_i     (req),
    .starved_i ({swait_q == MAX_WAIT, mwait_q == MAX_WAIT}),
    .rr_i      (rr_q),
    .winner_o  (pick),
    .valid_o   (pick_valid)
  );

  function automatic logic [7:0] next_wait(input logic r, input logic busy, input logic [7:0] cnt);
    if (!r || busy)          return 8'd0;
    else if (cnt >= MAX_WAIT) return MAX_WAIT;
    else                      return cnt + 8'd1;
  endfunction

  always_comb begin
    unique case (pick)
      OBJ:     pick_addr = obj_addr;
      BG1:     pick_addr = bg1_addr;
      BG2:     pick_addr = bg2_addr;
      MCPU:    pick_addr = mcpu_addr;
      SCPU:    pick_addr = scpu_addr;
      default: pick_addr = obj_addr;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    client_d   = client_q;
    sdr_addr_d = sdr_addr_q;
    sdr_req_d  = sdr_req_q;
    rr_d       = rr_q;
    dout_d     = dout_q;
    rdy_d      = '0;
    grant      = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        grant      = 1'b1;
        client_d   = pick;
        sdr_addr_d = pick_addr;
        sdr_req_d  = 1'b1;
        state_d    = ISSUE;
        if (pick == MCPU) rr_d = 1'b1;
        if (pick == SCPU) rr_d = 1'b0;
      end
      ISSUE: if (sdr_ack) begin
        sdr_req_d = 1'b0;
        state_d   = WAIT;
      end
      // A client that let go of req mid-flight still gets its dout, but no rdy.
      WAIT: if (sdr_valid) begin
        dout_d[client_q] = sdr_data;
        rdy_d[client_q]  = req[client_q];
        state_d          = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_m  = (state_q != IDLE && client_q == MCPU) || (grant && pick == MCPU);
    busy_s  = (state_q != IDLE && client_q == SCPU) || (grant && pick == SCPU);
    mwait_d = next_wait(mcpu_req, busy_m, mwait_q);
    swait_d = next_wait(scpu_req, busy_s, swait_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      client_q   <= OBJ;
      sdr_addr_q <= '0;
      sdr_req_q  <= 1'b0;
      rr_q       <= 1'b0;
      rdy_q      <= '0;
      mwait_q    <= '0;
      swait_q    <= '0;
      for (int i = 0; i < 5; i++) dout_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      client_q   <= client_d;
      sdr_addr_q <= sdr_addr_d;
      sdr_req_q  <= sdr_req_d;
      rr_q       <= rr_d;
      rdy_q      <= rdy_d;
      mwait_q    <= mwait_d;
      swait_q    <= swait_d;
      dout_q     <= dout_d;
    end
  end

  assign sdr_addr  = sdr_addr_q;
  assign sdr_req   = sdr_req_q;
  assign obj_rdy   = rdy_q[0];
  assign bg1_rdy   = rdy_q[1];
  assign bg2_rdy   = rdy_q[2];
  assign mcpu_rdy  = rdy_q[3];
  assign scpu_rdy  = rdy_q[4];
  assign obj_dout  = dout_q[0];
  assign bg1_dout  = dout_q[1];
  assign bg2_dout  = dout_q[2];
  assign mcpu_dout = dout_q[3];
  assign scpu_dout = dout_q[4];

endmodule

// File: doc/xsleena_sdr_arbiter.md
# xsleena_sdr_arbiter

Five-way SDRAM read arbiter for the XSleena core's ROM clients: main CPU, sub CPU, OBJ, BACK1 and BACK2. It sits between the core's per-client `sdr_*_addr/req/rdy/dout` ports and the single read port of the SDRAM controller. It keeps one transaction outstanding at a time. Video fetches get fixed priority, the two CPUs share the remaining bandwidth round-robin, and a starvation guard bounds CPU wait time.

## Interface
- `CPU_MAX_WAIT`, 64: cycles a CPU request may wait ungranted before it is promoted above video; range 1–255.
- `CLK` in 1: core clock; all logic on posedge.
- `RST` in 1: reset, synchronous and active-high.
- `mcpu_addr`, `scpu_addr`, `obj_addr`, `bg1_addr`, `bg2_addr` in 25 each: client word addresses.
- `mcpu_req`, `scpu_req`, `obj_req`, `bg1_req`, `bg2_req` in 1 each: level request; address must be stable while high.
- `mcpu_rdy`, `scpu_rdy`, `obj_rdy`, `bg1_rdy`, `bg2_rdy` out 1 each: one-cycle completion pulse.
- `mcpu_dout`, `scpu_dout`, `obj_dout`, `bg1_dout`, `bg2_dout` out 16 each: per-client data register.
- `sdr_addr` out 25: address to the controller.
- `sdr_req` out 1: read request, held until acknowledged.
- `sdr_ack` in 1: controller accepted the request (single pulse).
- `sdr_valid` in 1: read data valid (single pulse).
- `sdr_data` in 16: read data.

## Operation
- Client indices: 0 = OBJ, 1 = BG1, 2 = BG2, 3 = MCPU, 4 = SCPU.
- States:
  - IDLE: no transaction. If any request is high, register the winner index and its address, then go to ISSUE.
  - ISSUE: `sdr_req` = 1. When `sdr_ack` = 1, go to WAIT.
  - WAIT: when `sdr_valid` = 1, capture `sdr_data` into the granted client's dout register, then go to DONE.
  - DONE: pulse the granted client's rdy, then go to IDLE.
- Winner selection, evaluated only in IDLE, in priority order:
  1. Starved CPUs: a CPU is starved when its wait counter equals `CPU_MAX_WAIT`. If both are starved, the round-robin pointer picks.
  2. OBJ, then BG1, then BG2.
  3. CPUs by round-robin pointer.
- Round-robin pointer:
  - 1 bit; points to the CPU preferred next.
  - After a CPU is granted, it points to the other CPU.
  - Video grants do not move it.
- Wait counters, one per CPU:
  - Increment, saturating at `CPU_MAX_WAIT`, on every cycle the CPU's req is 1 and that CPU is not the granted client of the current or pending transaction.
  - Clear when the CPU is granted or when its req is 0.
- Client request protocol:
  - A high req sampled in IDLE is a new request.
  - A client must lower req, or present a new address, in the cycle after its rdy.
- Client drops req before rdy:
  - The transaction still runs to completion.
  - The dout register is still updated.
  - The rdy pulse is suppressed.
- dout registers:
  - Each holds the last data delivered to its client.
  - Each changes only in the WAIT→DONE transition for that client.
- Inputs outside their state: `sdr_valid` in IDLE or ISSUE, and `sdr_ack` outside ISSUE, are ignored.
- Reset:
  - All outputs clear to 0: every rdy, every dout, `sdr_req`, `sdr_addr`.
  - State goes to IDLE, both wait counters to 0, round-robin pointer to MCPU.
  - Reset mid-transaction abandons it. No rdy is issued. A late `sdr_valid` arriving in IDLE is discarded.

## Timing
- Request to SDRAM: req sampled high in IDLE at cycle n; `sdr_req` and `sdr_addr` are valid from cycle n+1.
- Hold: `sdr_addr` stays constant from ISSUE through DONE.
- Earliest completion: ack at n+1 and valid at n+2 give rdy at n+3 with dout valid the same cycle. This is the minimum latency of 3 cycles.
- Throughput: at most one grant per 4 cycles. The next IDLE evaluation is at the cycle after DONE.
- Stall tolerance: any number of cycles between ack and valid is accepted.
- Registered outputs: every rdy and `sdr_req` come straight from registers, with no combinational path from client inputs.

## Structure
- Package `xs_sdr_pkg` holds:
  - the client index enum `xs_sdr_client_t`, OBJ through SCPU;
  - the state enum `xs_sdr_state_t`: IDLE, ISSUE, WAIT, DONE;
  - the constants `XS_SDR_AW` = 25 and `XS_SDR_DW` = 16.
- Sub-module `xs_sdr_prio_pick` is combinational. It takes the 5 requests, 2 starved flags and the round-robin pointer, and returns the winner index and a valid flag. It is tested standalone.

## Test plan
- Single BG1 request at address 25'h0123456, ack 1 cycle later, valid 2 cycles later with data 16'hBEEF: `bg1_rdy` pulses exactly at n+3, `bg1_dout` = BEEF, all other rdy stay 0.
- OBJ, BG2 and MCPU all raise req in the same cycle, each reissued after its rdy: grants come in the order OBJ, BG2, MCPU, and `sdr_addr` matches each client in turn.
- MCPU and SCPU hold req continuously with no video traffic: grants alternate MCPU, SCPU, MCPU, SCPU.
- OBJ requests back-to-back continuously and SCPU holds req, with `CPU_MAX_WAIT` = 8: SCPU is granted no later than the first IDLE after its counter reaches 8; its counter then reads 0.
- MCPU drops req while in WAIT, then valid arrives with 16'h1234: no `mcpu_rdy`, `mcpu_dout` = 1234, state returns to IDLE.
- Reset asserted in WAIT, then `sdr_valid` pulses 2 cycles after reset is released: no rdy, all dout = 0, state IDLE, and the next request is served normally.
